// File: rtl/pb_debounce.sv
// ============================================================================
// pb_debounce : sync + per-channel debounce of active-low pushbuttons
// Rev 1.0
// ============================================================================
`default_nettype none

module pb_debounce #(
  parameter int PB_W            = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [PB_W-1:0] PB,
  output logic [PB_W-1:0] PB_LEVEL,
  output logic [PB_W-1:0] PB_PRESS,
  output logic [PB_W-1:0] PB_RELEASE
);

  typedef enum logic {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } pb_state_t;

  // Transition fires on the edge where the count would reach DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [PB_W-1:0] r_sync1;
  logic [PB_W-1:0] r_sync2;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= PB;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < PB_W; gi++) begin : g_ch
    pb_state_t        r_state;
    pb_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_press;
    logic             w_press_nxt;
    logic             r_release;
    logic             w_release_nxt;
    logic             w_differs;

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        r_state   <= ST_RELEASED;
        r_cnt     <= '0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_press   <= w_press_nxt;
        r_release <= w_release_nxt;
      end
    end

    always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      w_differs     = 1'b0;

      case (r_state)
        ST_RELEASED: w_differs = ~r_sync2[gi];
        ST_PRESSED:  w_differs =  r_sync2[gi];
        default:     w_differs = 1'b0;
      endcase

      // Any sample agreeing with the stable state restarts the count.
      if (!w_differs) begin
        w_cnt_nxt = '0;
      end else if (r_cnt == c_cnt_last) begin
        w_cnt_nxt = '0;
        case (r_state)
          ST_RELEASED: begin
            w_state_nxt = ST_PRESSED;
            w_press_nxt = 1'b1;
          end
          ST_PRESSED: begin
            w_state_nxt   = ST_RELEASED;
            w_release_nxt = 1'b1;
          end
          default: w_state_nxt = ST_RELEASED;
        endcase
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end

    assign PB_LEVEL[gi]   = (r_state == ST_PRESSED);
    assign PB_PRESS[gi]   = r_press;
    assign PB_RELEASE[gi] = r_release;
  end

endmodule

`default_nettype wire

// File: tb/tb_pb_debounce.sv
// ============================================================================
// tb_pb_debounce : directed + random bench for pb_debounce against a run-length model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pb_debounce;

  localparam int PB_W = 4;
  localparam int DC   = 4;

  logic            CLK;
  logic            nRST;
  logic [PB_W-1:0] PB;
  logic [PB_W-1:0] PB_LEVEL;
  logic [PB_W-1:0] PB_PRESS;
  logic [PB_W-1:0] PB_RELEASE;

  pb_debounce #(
    .PB_W            (PB_W),
    .DEBOUNCE_CYCLES (DC)
  ) u_dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .PB         (PB),
    .PB_LEVEL   (PB_LEVEL),
    .PB_PRESS   (PB_PRESS),
    .PB_RELEASE (PB_RELEASE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Model: input seen by the debouncer is PB delayed two edges; a level flips
  // once DC consecutive delayed samples disagree with it.
  logic [PB_W-1:0] m_d1, m_d2, m_level, m_press, m_rel;
  int              m_run [PB_W];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_d1    = '1;
    m_d2    = '1;
    m_level = '0;
    m_press = '0;
    m_rel   = '0;
    for (int i = 0; i < PB_W; i++) m_run[i] = 0;
  endtask

  task automatic model_edge(input logic [PB_W-1:0] pb);
    logic [PB_W-1:0] seen;
    logic            want;
    seen    = m_d2;
    m_d2    = m_d1;
    m_d1    = pb;
    m_press = '0;
    m_rel   = '0;
    for (int i = 0; i < PB_W; i++) begin
      want = ~seen[i];
      if (want != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DC) begin
          m_level[i] = want;
          m_run[i]   = 0;
          if (want) m_press[i] = 1'b1;
          else      m_rel[i]   = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  task automatic tick(input logic [PB_W-1:0] pb);
    @(negedge CLK);
    PB = pb;
    @(posedge CLK);
    model_edge(pb);
    #1;
    check("level",   32'(PB_LEVEL),   32'(m_level));
    check("press",   32'(PB_PRESS),   32'(m_press));
    check("release", 32'(PB_RELEASE), 32'(m_rel));
    check("excl",    32'(PB_PRESS & PB_RELEASE), 32'd0);
  endtask

  // Hold pb for n edges; report first edge index / count of pulses on masked channels.
  task automatic hold(input logic [PB_W-1:0] pb, input int n, input logic [PB_W-1:0] mask,
                      output int fp, output int np, output int fr, output int nr,
                      output logic [PB_W-1:0] press_at_fp);
    fp = 0; np = 0; fr = 0; nr = 0; press_at_fp = '0;
    for (int t = 1; t <= n; t++) begin
      tick(pb);
      if ((PB_PRESS & mask) != '0) begin
        np++;
        if (fp == 0) begin
          fp          = t;
          press_at_fp = PB_PRESS;
        end
      end
      if ((PB_RELEASE & mask) != '0) begin
        nr++;
        if (fr == 0) fr = t;
      end
    end
  endtask

  task automatic async_reset();
    #2;
    nRST = 1'b0;
    #1;
    check("rst_level",   32'(PB_LEVEL),   32'd0);
    check("rst_press",   32'(PB_PRESS),   32'd0);
    check("rst_release", 32'(PB_RELEASE), 32'd0);
    model_reset();
  endtask

  task automatic release_reset();
    @(posedge CLK);
    #2;
    nRST = 1'b1;
  endtask

  initial begin : main
    int fp, np, fr, nr, bad;
    logic [PB_W-1:0] pfp, cur;

    nRST = 1'b0;
    PB   = 4'b1111;
    model_reset();
    #12;
    check("init_level",   32'(PB_LEVEL),   32'd0);
    check("init_press",   32'(PB_PRESS),   32'd0);
    check("init_release", 32'(PB_RELEASE), 32'd0);

    // Button 0 held through reset release.
    PB = 4'b1110;
    release_reset();
    hold(4'b1110, 10, 4'b0001, fp, np, fr, nr, pfp);
    check("rsthold_edge", 32'(fp), 32'd6);
    check("rsthold_cnt",  32'(np), 32'd1);
    check("rsthold_lvl",  32'(PB_LEVEL), 32'b0001);

    // Release.
    hold(4'b1111, 8, 4'b0001, fp, np, fr, nr, pfp);
    check("rel_edge", 32'(fr), 32'd6);
    check("rel_cnt",  32'(nr), 32'd1);
    check("rel_lvl",  32'(PB_LEVEL), 32'd0);

    // Clean press, held well past acceptance.
    hold(4'b1110, 12, 4'b0001, fp, np, fr, nr, pfp);
    check("press_edge", 32'(fp), 32'd6);
    check("press_cnt",  32'(np), 32'd1);
    check("press_vec",  32'(pfp), 32'b0001);
    check("press_lvl",  32'(PB_LEVEL), 32'b0001);
    hold(4'b1111, 8, 4'b0001, fp, np, fr, nr, pfp);

    // Bounce rejection on channel 1.
    bad = 0;
    for (int t = 0; t < 15; t++) begin
      tick((t < 3 || (t >= 4 && t < 7)) ? 4'b1101 : 4'b1111);
      if (PB_LEVEL[1] || PB_PRESS[1] || PB_RELEASE[1]) bad++;
    end
    check("bounce_rej", 32'(bad), 32'd0);

    // Bounce then settle on channel 2.
    tick(4'b1011);
    tick(4'b1011);
    tick(4'b1111);
    hold(4'b1011, 12, 4'b0100, fp, np, fr, nr, pfp);
    check("settle_edge", 32'(fp), 32'd6);
    check("settle_cnt",  32'(np), 32'd1);
    hold(4'b1111, 8, 4'b0100, fp, np, fr, nr, pfp);

    // All channels at once, then async reset while all are pressed.
    hold(4'b0000, 8, 4'b1111, fp, np, fr, nr, pfp);
    check("all_edge", 32'(fp),  32'd6);
    check("all_vec",  32'(pfp), 32'b1111);
    async_reset();
    PB = 4'b1111;
    release_reset();
    hold(4'b1111, 4, 4'b1111, fp, np, fr, nr, pfp);
    check("rst_nopulse", 32'(np + nr), 32'd0);

    // Reset with the count at 2, button still held afterwards.
    for (int t = 0; t < 4; t++) tick(4'b0000);
    async_reset();
    PB = 4'b0000;
    release_reset();
    hold(4'b0000, 10, 4'b1111, fp, np, fr, nr, pfp);
    check("midrst_edge", 32'(fp),  32'd6);
    check("midrst_cnt",  32'(np),  32'd1);
    check("midrst_vec",  32'(pfp), 32'b1111);

    // Random bouncing with occasional asynchronous resets.
    cur = 4'b1111;
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < PB_W; i++)
        if ($urandom_range(0, 6) == 0) cur[i] = ~cur[i];
      tick(cur);
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
        release_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
